// File: rtl/imem_stream_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = loader side, slave = host link / memory side.
interface imem_stream_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [31:0]           imem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_stream_loader.sv
// Program loader: length-prefixed little-endian byte stream -> instruction memory words.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_stream_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  imem_stream_loader_if.master        bus,
  output logic                        cpu_hold,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [15:0]                 word_count
);

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           wbuf_q, wbuf_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [15:0]           wcount_q, wcount_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif
  logic [15:0]           n_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      wbuf_q   <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wcount_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      wbuf_q   <= wbuf_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wcount_q <= wcount_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    wbuf_d       = wbuf_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    wcount_d     = wcount_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    bus.rx_ready = 1'b0;
    n_len        = {bus.rx_data, len_q[7:0]};

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d  = S_LEN_LO;
          idx_d    = '0;
          waddr_d  = '0;
          wcount_d = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d   = '0;
`endif
        end
      end
      S_LEN_LO: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid) begin
          len_d   = {8'h00, bus.rx_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid) begin
          len_d = n_len;
          // Oversized images are rejected here, before any memory write.
          if (n_len == 16'd0)                  state_d = S_DONE;
          else if ({16'd0, n_len} > MAX_WORDS) state_d = S_ERROR;
          else                                 state_d = S_DATA;
        end
      end
      S_DATA: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid) begin
          idx_d  = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.rx_data;
`endif
          case (idx_q)
            2'd0:    wbuf_d[7:0]   = bus.rx_data;
            2'd1:    wbuf_d[15:8]  = bus.rx_data;
            2'd2:    wbuf_d[23:16] = bus.rx_data;
            default: begin
              wdata_d = {bus.rx_data, wbuf_q};
              waddr_d = ADDR_WIDTH'(wcount_q);
              state_d = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        wcount_d = wcount_q + 16'd1;
        if ((wcount_q + 16'd1) != len_q) state_d = S_DATA;
`ifdef LOADER_CHECKSUM_EN
        else                              state_d = S_CSUM;
`else
        else                              state_d = S_DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid) state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.imem_we    = (state_q == S_WRITE);
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign word_count     = wcount_q;
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_ERROR);
`ifdef LOADER_CHECKSUM_EN
  assign busy = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA) ||
                (state_q == S_WRITE)  || (state_q == S_CSUM);
`else
  assign busy = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA) ||
                (state_q == S_WRITE);
`endif
  // A rejected image keeps the core parked in reset.
  assign cpu_hold = busy || (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader: directed table, hand sequences, randomized frames vs model.
module tb_imem_stream_loader;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [95:0]  fr;
    int unsigned  nb;
    int unsigned  gap;
    bit           exp_done;
    bit           exp_err;
    int unsigned  exp_wc;
    logic [31:0]  exp_w0;
    logic [31:0]  exp_w1;
  } vec_t;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start_v = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  int unsigned tests = 0;
  int unsigned fails = 0;

  imem_stream_loader_if #(.ADDR_WIDTH(10)) bus_a ();
  imem_stream_loader_if #(.ADDR_WIDTH(4))  bus_b ();

  assign bus_a.rx_data  = rx_data;
  assign bus_a.rx_valid = rx_valid & ~sel;
  assign bus_b.rx_data  = rx_data;
  assign bus_b.rx_valid = rx_valid & sel;

  logic        hold_a, busy_a, done_a, err_a, hold_b, busy_b, done_b, err_b;
  logic [15:0] wc_a, wc_b;

  imem_stream_loader #(.ADDR_WIDTH(10)) u_a (
    .clk(clk), .rst(rst), .start(start_v & ~sel), .bus(bus_a),
    .cpu_hold(hold_a), .busy(busy_a), .done(done_a), .error(err_a), .word_count(wc_a)
  );

  imem_stream_loader #(.ADDR_WIDTH(4)) u_b (
    .clk(clk), .rst(rst), .start(start_v & sel), .bus(bus_b),
    .cpu_hold(hold_b), .busy(busy_b), .done(done_b), .error(err_b), .word_count(wc_b)
  );

  logic        cur_ready, cur_we, cur_hold, cur_busy, cur_done, cur_err;
  logic [15:0] cur_wc, cur_waddr;
  logic [31:0] cur_wdata;
  assign cur_ready = sel ? bus_b.rx_ready : bus_a.rx_ready;
  assign cur_we    = sel ? bus_b.imem_we  : bus_a.imem_we;
  assign cur_waddr = sel ? 16'(bus_b.imem_waddr) : 16'(bus_a.imem_waddr);
  assign cur_wdata = sel ? bus_b.imem_wdata : bus_a.imem_wdata;
  assign cur_hold  = sel ? hold_b : hold_a;
  assign cur_busy  = sel ? busy_b : busy_a;
  assign cur_done  = sel ? done_b : done_a;
  assign cur_err   = sel ? err_b  : err_a;
  assign cur_wc    = sel ? wc_b   : wc_a;

  wr_t wlog[$];
  always @(negedge clk) if (cur_we) wlog.push_back('{addr: 32'(cur_waddr), data: cur_wdata});

  // Reference results for the frame most recently handed to the model.
  logic [31:0] exp_w[$];
  bit          exp_done, exp_err;
  int unsigned exp_wc;
  int unsigned base;
  bq_t         rq;
  vec_t        vecs[8];
  int unsigned nvec;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model(input bq_t fr, input int unsigned maxw);
    int unsigned n;
    logic [7:0]  x;
    exp_w.delete();
    exp_done = 0; exp_err = 0; exp_wc = 0; x = 8'h00;
    n = {16'd0, fr[1], fr[0]};
    if (n == 0) begin exp_done = 1; return; end
    if (n > maxw) begin exp_err = 1; return; end
    for (int unsigned i = 0; i < n; i++) begin
      exp_w.push_back({fr[2+4*i+3], fr[2+4*i+2], fr[2+4*i+1], fr[2+4*i]});
      for (int unsigned k = 0; k < 4; k++) x = x ^ fr[2+4*i+k];
    end
    exp_wc = n;
`ifdef LOADER_CHECKSUM_EN
    if (fr[2+4*n] == x) exp_done = 1; else exp_err = 1;
`else
    exp_done = 1;
`endif
  endtask

  task automatic idle_cycles(input int unsigned n);
    rx_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      rx_data = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned waited;
    logic rdy;
    if (gap == 1) idle_cycles(1);
    else if (gap == 2) idle_cycles($urandom_range(0, 2));
    rx_valid = 1'b1;
    rx_data  = b;
    waited   = 0;
    do begin
      @(negedge clk);
      rdy = cur_ready;
      @(posedge clk); #1;
      waited++;
    end while (!rdy && waited < 64);
    if (!rdy) begin
      tests++; fails++;
      $display("FAIL accept_timeout: byte %h not accepted within 64 cycles", b);
    end
  endtask

  task automatic do_start();
    rx_valid = 1'b0;
    start_v  = 1'b1;
    @(posedge clk); #1;
    start_v  = 1'b0;
  endtask

  task automatic settle();
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_end(input string nm);
    int unsigned nw;
    nw = wlog.size() - base;
    chk({nm, ".done"},  {31'd0, cur_done},  {31'd0, exp_done});
    chk({nm, ".error"}, {31'd0, cur_err},   {31'd0, exp_err});
    chk({nm, ".hold"},  {31'd0, cur_hold},  {31'd0, exp_err});
    chk({nm, ".busy"},  {31'd0, cur_busy},  32'd0);
    chk({nm, ".ready"}, {31'd0, cur_ready}, 32'd0);
    chk({nm, ".wc"},    {16'd0, cur_wc},    exp_wc);
    chk({nm, ".nwr"},   nw,                 exp_w.size());
    for (int unsigned i = 0; i < nw && i < exp_w.size(); i++) begin
      chk({nm, ".waddr"}, wlog[base+i].addr, i);
      chk({nm, ".wdata"}, wlog[base+i].data, exp_w[i]);
    end
  endtask

  task automatic run_vec(input int unsigned v);
    int unsigned nw;
    string nm;
    nm   = $sformatf("vec%0d", v);
    base = wlog.size();
    do_start();
    for (int unsigned k = 0; k < vecs[v].nb; k++)
      send_byte(vecs[v].fr[8*(vecs[v].nb-1-k) +: 8], vecs[v].gap);
    settle();
    nw = wlog.size() - base;
    chk({nm, ".done"},  {31'd0, cur_done}, {31'd0, vecs[v].exp_done});
    chk({nm, ".error"}, {31'd0, cur_err},  {31'd0, vecs[v].exp_err});
    chk({nm, ".hold"},  {31'd0, cur_hold}, {31'd0, vecs[v].exp_err});
    chk({nm, ".busy"},  {31'd0, cur_busy}, 32'd0);
    chk({nm, ".wc"},    {16'd0, cur_wc},   vecs[v].exp_wc);
    chk({nm, ".nwr"},   nw,                vecs[v].exp_wc);
    if (nw >= 1 && vecs[v].exp_wc >= 1) begin
      chk({nm, ".a0"}, wlog[base].addr, 32'd0);
      chk({nm, ".d0"}, wlog[base].data, vecs[v].exp_w0);
    end
    if (nw >= 2 && vecs[v].exp_wc >= 2) begin
      chk({nm, ".a1"}, wlog[base+1].addr, 32'd1);
      chk({nm, ".d1"}, wlog[base+1].data, vecs[v].exp_w1);
    end
  endtask

  task automatic run_random(input int unsigned n, input int unsigned maxw, input int unsigned gap,
                            input string nm);
    logic [7:0] x;
    rq.delete();
    rq.push_back(n[7:0]);
    rq.push_back(n[15:8]);
    x = 8'h00;
    if (n > 0 && n <= maxw) begin
      for (int unsigned i = 0; i < 4 * n; i++) begin
        rq.push_back(8'($urandom));
        x = x ^ rq[rq.size()-1];
      end
`ifdef LOADER_CHECKSUM_EN
      rq.push_back(x ^ (($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00));
`endif
    end
    model(rq, maxw);
    base = wlog.size();
    do_start();
    foreach (rq[i]) send_byte(rq[i], gap);
    settle();
    check_end(nm);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef LOADER_CHECKSUM_EN
    vecs[0] = '{fr: 96'h0200130_5A000930510_0030, nb: 11, gap: 0, exp_done: 1, exp_err: 0,
                exp_wc: 2, exp_w0: 32'h00A00513, exp_w1: 32'h00100593};
    vecs[1] = vecs[0];
    vecs[1].gap = 1;
    vecs[2] = '{fr: 96'h0000, nb: 2, gap: 0, exp_done: 1, exp_err: 0,
                exp_wc: 0, exp_w0: 32'h0, exp_w1: 32'h0};
    vecs[3] = '{fr: 96'h0100EFBEADDE22, nb: 7, gap: 2, exp_done: 1, exp_err: 0,
                exp_wc: 1, exp_w0: 32'hDEADBEEF, exp_w1: 32'h0};
    vecs[4] = '{fr: 96'h01001305A000B6, nb: 7, gap: 0, exp_done: 1, exp_err: 0,
                exp_wc: 1, exp_w0: 32'h00A00513, exp_w1: 32'h0};
    vecs[5] = '{fr: 96'h01001305A000B7, nb: 7, gap: 0, exp_done: 0, exp_err: 1,
                exp_wc: 1, exp_w0: 32'h00A00513, exp_w1: 32'h0};
    nvec = 6;
`else
    vecs[0] = '{fr: 96'h0200130_5A000930510_00, nb: 10, gap: 0, exp_done: 1, exp_err: 0,
                exp_wc: 2, exp_w0: 32'h00A00513, exp_w1: 32'h00100593};
    vecs[1] = vecs[0];
    vecs[1].gap = 1;
    vecs[2] = '{fr: 96'h0000, nb: 2, gap: 0, exp_done: 1, exp_err: 0,
                exp_wc: 0, exp_w0: 32'h0, exp_w1: 32'h0};
    vecs[3] = '{fr: 96'h0100EFBEADDE, nb: 6, gap: 2, exp_done: 1, exp_err: 0,
                exp_wc: 1, exp_w0: 32'hDEADBEEF, exp_w1: 32'h0};
    nvec = 4;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.ready", {31'd0, bus_a.rx_ready}, 32'd0);
    chk("rst.we",    {31'd0, bus_a.imem_we},  32'd0);
    chk("rst.hold",  {31'd0, hold_a},         32'd0);
    chk("rst.busy",  {31'd0, busy_a},         32'd0);
    chk("rst.flags", {30'd0, done_a, err_a},  32'd0);
    chk("rst.waddr", 32'(bus_a.imem_waddr),   32'd0);
    chk("rst.wdata", bus_a.imem_wdata,        32'd0);
    chk("rst.wc",    {16'd0, wc_a},           32'd0);
    chk("rst_b.hold", {31'd0, hold_b},        32'd0);
    @(posedge clk); #1;

    for (int unsigned v = 0; v < nvec; v++) run_vec(v);

    // Reset mid-word discards the partial word, then a clean load from address 0
    base = wlog.size();
    do_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h13, 0); send_byte(8'h05, 0);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst.ready", {31'd0, cur_ready}, 32'd0);
    chk("midrst.busy",  {31'd0, cur_busy},  32'd0);
    chk("midrst.hold",  {31'd0, cur_hold},  32'd0);
    chk("midrst.flags", {30'd0, cur_done, cur_err}, 32'd0);
    chk("midrst.wc",    {16'd0, cur_wc},    32'd0);
    chk("midrst.wdata", cur_wdata,          32'd0);
    chk("midrst.nwr",   wlog.size() - base, 32'd0);
    @(posedge clk); #1;
    run_vec(0);

    // start during DATA is ignored; start from DONE clears done next cycle
    do_start();
    @(negedge clk);
    chk("restart.done_clr", {31'd0, cur_done}, 32'd0);
    chk("restart.busy",     {31'd0, cur_busy}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    rq.delete();
    rq.push_back(8'h01); rq.push_back(8'h00);
    rq.push_back(8'h44); rq.push_back(8'h33); rq.push_back(8'h22); rq.push_back(8'h11);
`ifdef LOADER_CHECKSUM_EN
    rq.push_back(8'h44);
`endif
    model(rq, 1024);
    base = wlog.size();
    do_start();
    for (int unsigned i = 0; i < 4; i++) send_byte(rq[i], 0);
    do_start();
    for (int unsigned i = 4; i < rq.size(); i++) send_byte(rq[i], 0);
    settle();
    check_end("busy_start");

    // start and rst together: reset wins
    @(posedge clk); #1;
    start_v = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_vs_start.busy",  {31'd0, cur_busy},  32'd0);
    chk("rst_vs_start.ready", {31'd0, cur_ready}, 32'd0);
    chk("rst_vs_start.done",  {31'd0, cur_done},  32'd0);
    @(posedge clk); #1;

    for (int unsigned i = 0; i < 20; i++)
      run_random((i % 7 == 6) ? 0 : $urandom_range(1, 5), 1024, 2, $sformatf("rnd_a%0d", i));

    // Small memory: oversized image rejected before any write
    sel = 1'b1;
    @(posedge clk); #1;
    base = wlog.size();
    do_start();
    send_byte(8'h11, 0); send_byte(8'h00, 0);
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("over.error", {31'd0, cur_err},   32'd1);
    chk("over.hold",  {31'd0, cur_hold},  32'd1);
    chk("over.ready", {31'd0, cur_ready}, 32'd0);
    chk("over.busy",  {31'd0, cur_busy},  32'd0);
    chk("over.wc",    {16'd0, cur_wc},    32'd0);
    chk("over.nwr",   wlog.size() - base, 32'd0);
    @(posedge clk); #1;
    rx_valid = 1'b0;

    run_random(16, 16, 0, "full16");
    run_random(17, 16, 0, "over17");
    for (int unsigned i = 0; i < 10; i++)
      run_random($urandom_range(0, 20), 16, $urandom_range(0, 2), $sformatf("rnd_b%0d", i));
    sel = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
